// File: rtl/amiq_sock_tx_arbiter.sv
// amiq_sock_tx_arbiter: round-robin, message-atomic arbiter sharing one socket tx channel with stall timeout
module amiq_sock_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 8,
  parameter int TIMEOUT_W = 16,
  localparam int SRC_W = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      connected,
  input  logic [TIMEOUT_W-1:0]      timeout_cycles,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_valid,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_last,
  output logic [SRC_W-1:0]          tx_src,
  input  logic                      tx_ready,
  output logic                      msg_done,
  output logic                      msg_timeout,
  output logic [SRC_W-1:0]          msg_src,
  output logic                      busy
);
  typedef enum logic [1:0] {IDLE, XFER, FLUSH} state_t;
  state_t state, state_nx;
  logic [SRC_W-1:0] ptr, gnt, pick, gnt_inc;
  logic [SRC_W:0] idx;
  logic [TIMEOUT_W-1:0] cnt, lim, cnt_sat;
  logic found, xfer, hs, stall, hit, grant, done_ev, drain;
  assign xfer = state == XFER;
  assign tx_valid = xfer && req_valid[gnt];
  assign tx_data = xfer ? req_data[gnt*DATA_W +: DATA_W] : '0;
  assign tx_last = xfer && req_last[gnt];
  assign tx_src = xfer ? gnt : '0;
  assign busy = state != IDLE;
  assign hs = tx_valid && tx_ready;
  assign stall = tx_valid && !tx_ready;
  assign done_ev = hs && tx_last;
  assign drain = state == FLUSH && req_valid[gnt] && req_last[gnt];
  assign cnt_sat = &cnt ? cnt : cnt + 1'b1;
  assign hit = stall && lim != '0 && cnt_sat >= lim;
  assign grant = state == IDLE && connected && found;
  assign gnt_inc = (gnt == SRC_W'(NUM_REQ-1)) ? '0 : gnt + 1'b1;
  // first valid requester at or after ptr, wrapping modulo NUM_REQ
  always_comb begin
    found = 1'b0;
    pick = ptr;
    idx = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (SRC_W+1)'(i);
      if (idx >= (SRC_W+1)'(NUM_REQ)) idx = idx - (SRC_W+1)'(NUM_REQ);
      if (req_valid[idx[SRC_W-1:0]]) begin
        found = 1'b1;
        pick = idx[SRC_W-1:0];
      end
    end
  end
  // only the granted requester sees ready; FLUSH swallows its beats unconditionally
  always_comb begin
    req_ready = '0;
    req_ready[gnt] = xfer ? tx_ready : state == FLUSH;
  end
  // next state: a last-beat handshake wins over a timeout in the same cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = grant ? XFER : IDLE;
      XFER:    state_nx = done_ev ? IDLE : hit ? FLUSH : XFER;
      FLUSH:   state_nx = drain ? IDLE : FLUSH;
      default: state_nx = IDLE;
    endcase
  end
  // state, grant, stall counter and message status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      gnt <= '0;
      cnt <= '0;
      lim <= '0;
      msg_done <= 1'b0;
      msg_timeout <= 1'b0;
      msg_src <= '0;
    end else begin
      state <= state_nx;
      msg_done <= done_ev;
      msg_timeout <= hit;
      if (done_ev || hit) msg_src <= gnt;
      if (done_ev || drain) ptr <= gnt_inc;
      if (grant) begin
        gnt <= pick;
        lim <= timeout_cycles;
        cnt <= '0;
      end else if (hs) begin
        cnt <= '0;
      end else if (stall) begin
        cnt <= cnt_sat;
      end
    end
  end
endmodule

// File: tb/tb_amiq_sock_tx_arbiter.sv
// tb_amiq_sock_tx_arbiter: directed scoreboard bench for the socket tx arbiter
module tb_amiq_sock_tx_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, connected = 1'b0, tx_ready = 1'b0;
  logic [15:0] timeout_cycles = '0;
  logic [3:0] req_valid = '0, req_last = '0, req_ready;
  logic [31:0] req_data = '0;
  logic tx_valid, tx_last, msg_done, msg_timeout, busy;
  logic [7:0] tx_data;
  logic [1:0] tx_src, msg_src;
  int checks = 0, errors = 0;
  int exp_beats[$];
  int exp_msgs[$];
  logic [8:0] mem [4][32];
  int hd [4];
  int tl [4];
  logic [3:0] acc;
  logic last_hs = 1'b0;

  amiq_sock_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .connected(connected), .timeout_cycles(timeout_cycles),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_src(tx_src),
    .tx_ready(tx_ready), .msg_done(msg_done), .msg_timeout(msg_timeout),
    .msg_src(msg_src), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = hd[i] != tl[i];
      req_last[i] = mem[i][hd[i]][8];
      req_data[i*8 +: 8] = mem[i][hd[i]][7:0];
    end
  endtask

  task automatic send(input int r, input int n, input int base);
    for (int k = 0; k < n; k++) begin
      mem[r][tl[r]] = {k == n-1, 8'(base + k)};
      tl[r]++;
    end
    drive();
  endtask

  task automatic expect_msg(input int r, input int n, input int base);
    for (int k = 0; k < n; k++) exp_beats.push_back((r << 16) | ((k == n-1) << 8) | ((base + k) & 255));
    exp_msgs.push_back(256 | r);
  endtask

  task automatic clear_src();
    for (int i = 0; i < 4; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    drive();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && (busy || req_valid != 0 || exp_beats.size() != 0 || exp_msgs.size() != 0)) begin
      step();
      n++;
    end
    chk({name, "_idle_timeout"}, n >= budget, 0);
  endtask

  // requester model: pops a beat after every accepted handshake
  initial begin
    for (int i = 0; i < 4; i++) begin
      hd[i] = 0;
      tl[i] = 0;
      for (int k = 0; k < 32; k++) mem[i][k] = '0;
    end
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (acc[i]) hd[i]++;
      drive();
    end
  end

  // monitor: compares every tx beat and status pulse against the scoreboard
  initial forever begin
    int act, e;
    @(negedge clk);
    if (rst_n) begin
      if (last_hs) chk("gap_after_last", {30'd0, tx_valid, busy}, 0);
      last_hs = tx_valid && tx_ready && tx_last;
      if (tx_valid && tx_ready) begin
        act = (int'(tx_src) << 16) | (int'(tx_last) << 8) | int'(tx_data);
        if (exp_beats.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got 0x%0h expected none at %0t", act, $time);
        end else begin
          e = exp_beats.pop_front();
          chk("tx_beat", act, e);
        end
      end
      if (msg_done || msg_timeout) begin
        chk("pulse_excl", int'(msg_done && msg_timeout), 0);
        act = (msg_timeout ? 512 : 256) | int'(msg_src);
        if (exp_msgs.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_msg: got 0x%0h expected none at %0t", act, $time);
        end else begin
          e = exp_msgs.pop_front();
          chk("msg_pulse", act, e);
        end
      end
    end else begin
      last_hs = 1'b0;
    end
  end

  initial begin
    repeat (3) step();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_msg", {msg_done, msg_timeout, msg_src}, 0);
    rst_n = 1'b1;
    connected = 1'b1;
    tx_ready = 1'b1;
    step();
    // single 3-beat message from requester 2
    expect_msg(2, 3, 'hA1);
    send(2, 3, 'hA1);
    chk("t1_no_comb_grant", tx_valid, 0);
    step();
    chk("t1_latency_valid", tx_valid, 1);
    chk("t1_src", tx_src, 2);
    wait_idle("t1", 50);
    // ptr now 3: requester 3 must win over 0
    expect_msg(3, 1, 'hC3);
    expect_msg(0, 1, 'hC0);
    send(0, 1, 'hC0);
    send(3, 1, 'hC3);
    wait_idle("t1_ptr", 50);
    // reset returns ptr to 0 for the round-robin sweep
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    expect_msg(0, 2, 'h00);
    expect_msg(1, 2, 'h10);
    expect_msg(2, 2, 'h20);
    expect_msg(3, 2, 'h30);
    expect_msg(0, 2, 'h08);
    send(0, 2, 'h00);
    send(0, 2, 'h08);
    send(1, 2, 'h10);
    send(2, 2, 'h20);
    send(3, 2, 'h30);
    wait_idle("t2", 100);
    // stall timeout on requester 1, then requester 2 is served
    timeout_cycles = 16'd5;
    tx_ready = 1'b0;
    exp_msgs.push_back(512 | 1);
    expect_msg(2, 1, 'h77);
    send(1, 4, 'hB0);
    send(2, 1, 'h77);
    repeat (5) step();
    chk("t3_before_timeout", {29'd0, msg_timeout, busy, tx_valid}, 3);
    step();
    chk("t3_timeout_pulse", msg_timeout, 1);
    chk("t3_flush_tx_valid", tx_valid, 0);
    chk("t3_flush_ready", req_ready, 4'b0010);
    tx_ready = 1'b1;
    wait_idle("t3", 50);
    chk("t3_drained", tl[1] - hd[1], 0);
    // timeout disabled: long stall never aborts
    timeout_cycles = 16'd0;
    tx_ready = 1'b0;
    expect_msg(0, 2, 'h40);
    send(0, 2, 'h40);
    repeat (1000) step();
    chk("t4_still_stalled", {30'd0, busy, tx_valid}, 3);
    tx_ready = 1'b1;
    wait_idle("t4", 50);
    // connection gating
    connected = 1'b0;
    expect_msg(0, 2, 'h50);
    send(0, 2, 'h50);
    repeat (3) step();
    chk("t5_no_grant", busy, 0);
    connected = 1'b1;
    step();
    chk("t5_grant", {29'd0, busy, tx_src}, 4);
    connected = 1'b0;
    wait_idle("t5", 50);
    connected = 1'b1;
    // reset in the middle of a 4-beat message
    exp_beats.push_back('h60);
    send(0, 4, 'h60);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tx", {tx_valid, tx_last, tx_src, tx_data}, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", req_ready, 0);
    clear_src();
    step();
    rst_n = 1'b1;
    step();
    expect_msg(0, 1, 'h68);
    expect_msg(3, 1, 'h6B);
    send(0, 1, 'h68);
    send(3, 1, 'h6B);
    step();
    chk("t6_first_grant", tx_src, 0);
    wait_idle("t6", 50);
    chk("left_beats", exp_beats.size(), 0);
    chk("left_msgs", exp_msgs.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
